// File: rtl/wptr_handler_full.sv
`default_nettype none
// ============================================================================
//  Module   : wptr_handler_full
//  Purpose  : Write-side pointer and flag logic of a dual-clock async FIFO.
//             Holds the write pointer in binary (RAM address) and Gray
//             (crossed to the read domain). Compares it against the read
//             pointer already synchronised into wclk. From that comparison it
//             produces registered full, almost-full, fill-level and sticky
//             overflow flags.
//  Options  : WPTR_DROP_CNT_EN - when defined, adds the 8-bit saturating
//             dropped-write counter output wDropCnt.
//  Revision : 1.0 - initial release
// ============================================================================
module wptr_handler_full #(
    parameter int ADDR_SIZE    = 12,
    parameter int AFULL_THRESH = 2**ADDR_SIZE - 4
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   rptr_s,
    input  logic                 wOvfClr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wFull,
    output logic                 wAlmostFull,
    output logic [ADDR_SIZE:0]   wLevel,
    output logic                 wOverflow
`ifdef WPTR_DROP_CNT_EN
    ,
    output logic [7:0]           wDropCnt
`endif
);

    // Threshold resized to the pointer width so the level compare is width-matched.
    localparam logic [ADDR_SIZE:0] c_AFULL_THRESH = (ADDR_SIZE+1)'(AFULL_THRESH);

    // Registered state
    logic [ADDR_SIZE:0] r_wbin;
    logic [ADDR_SIZE:0] r_wptr;
    logic               r_full;
    logic               r_afull;
    logic [ADDR_SIZE:0] r_level;
    logic               r_ovf;

    // Next-state combinational terms
    logic               w_wen;
    logic               w_drop;
    logic [ADDR_SIZE:0] w_wbinnext;
    logic [ADDR_SIZE:0] w_wgraynext;
    logic [ADDR_SIZE:0] w_rbin_s;
    logic [ADDR_SIZE:0] w_level_next;
    logic [ADDR_SIZE:0] w_full_cmp;

    // A write is accepted only while not full; a write attempted while full is dropped.
    assign w_wen  = winc & ~r_full;
    assign w_drop = winc &  r_full;

    assign w_wbinnext  = r_wbin + (ADDR_SIZE+1)'(w_wen);
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

    // Gray-to-binary of the synchronised read pointer: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin_s = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            w_rbin_s[i] = ^(rptr_s >> i);
        end
    end

    // Modular difference; the pointer-domain wrap bit lets this reach exactly 2**ADDR_SIZE when full.
    assign w_level_next = w_wbinnext - w_rbin_s;

    // Full in Gray terms: the top two bits are inverted relative to the read pointer, and the rest are equal.
    assign w_full_cmp = {~rptr_s[ADDR_SIZE:ADDR_SIZE-1], rptr_s[ADDR_SIZE-2:0]};

    // Pointer registers advance every edge by the accepted-write amount.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_wbin <= '0;
            r_wptr <= '0;
        end else begin
            r_wbin <= w_wbinnext;
            r_wptr <= w_wgraynext;
        end
    end

    // Status flags are computed from the next pointer, so they track the edge that changes occupancy.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_level <= '0;
        end else begin
            r_full  <= (w_wgraynext == w_full_cmp);
            r_afull <= (w_level_next >= c_AFULL_THRESH);
            r_level <= w_level_next;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (wOvfClr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef WPTR_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of dropped writes; a clear that coincides with a drop restarts the count at one.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            if (wOvfClr) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (wOvfClr) begin
            r_drop_cnt <= 8'd0;
        end
    end

    assign wDropCnt = r_drop_cnt;
`endif

    assign waddr       = r_wbin[ADDR_SIZE-1:0];
    assign wptr        = r_wptr;
    assign wFull       = r_full;
    assign wAlmostFull = r_afull;
    assign wLevel      = r_level;
    assign wOverflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wptr_handler_full.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_wptr_handler_full
//  Purpose  : Self-checking bench for wptr_handler_full (ADDR_SIZE=4).
//             It runs directed scenarios followed by random traffic. Each
//             result is compared against an occupancy-count reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wptr_handler_full;

    localparam int AS    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int TH    = 14;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          winc;
    logic [AS:0]   rptr_s;
    logic          wOvfClr;
    logic [AS-1:0] waddr;
    logic [AS:0]   wptr;
    logic          wFull;
    logic          wAlmostFull;
    logic [AS:0]   wLevel;
    logic          wOverflow;
`ifdef WPTR_DROP_CNT_EN
    logic [7:0]    wDropCnt;
`endif

    wptr_handler_full #(.ADDR_SIZE(AS), .AFULL_THRESH(TH)) u_dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .rptr_s      (rptr_s),
        .wOvfClr     (wOvfClr),
        .waddr       (waddr),
        .wptr        (wptr),
        .wFull       (wFull),
        .wAlmostFull (wAlmostFull),
        .wLevel      (wLevel),
        .wOverflow   (wOverflow)
`ifdef WPTR_DROP_CNT_EN
        ,
        .wDropCnt    (wDropCnt)
`endif
    );

    always #5 wclk = ~wclk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: pointers held as plain write/read counts (mod 2*DEPTH)
    int m_wb;
    int m_rb;
    int m_lvl;
    bit m_full;
    bit m_ovf;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AS:0] to_gray(input int b);
        logic [AS:0] v;
        v = b[AS:0];
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        m_wb = 0; m_rb = 0; m_lvl = 0; m_full = 0; m_ovf = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_waddr"}, 32'(waddr), 32'(m_wb % DEPTH));
        chk({tag, "_wptr"},  32'(wptr),  32'(to_gray(m_wb)));
        chk({tag, "_full"},  32'(wFull), 32'(m_full));
        chk({tag, "_afull"}, 32'(wAlmostFull), 32'(m_lvl >= TH));
        chk({tag, "_level"}, 32'(wLevel), 32'(m_lvl));
        chk({tag, "_ovf"},   32'(wOverflow), 32'(m_ovf));
`ifdef WPTR_DROP_CNT_EN
        chk({tag, "_dcnt"},  32'(wDropCnt), 32'(m_cnt));
`endif
    endtask

    // One wclk cycle: drive inputs, clock, advance the model, compare every output.
    task automatic cyc(input bit inc, input int rb, input bit clr, input string tag);
        bit wen;
        bit drop;
        winc    = inc;
        rptr_s  = to_gray(rb);
        wOvfClr = clr;
        @(posedge wclk);
        #1;
        wen  = inc && !m_full;
        drop = inc && m_full;
        m_wb  = (m_wb + int'(wen)) % PMOD;
        m_rb  = rb;
        m_lvl = (m_wb - rb + PMOD) % PMOD;
        m_full = (m_lvl == DEPTH);
        if (drop)      m_ovf = 1;
        else if (clr)  m_ovf = 0;
        if (drop)      m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
        else if (clr)  m_cnt = 0;
        winc    = 1'b0;
        wOvfClr = 1'b0;
        check_all(tag);
    endtask

    task automatic apply_reset();
        @(negedge wclk);
        wrst = 1'b0;
        #1;
        model_reset();
        rptr_s = '0;
        check_all("rst");
        @(negedge wclk);
        wrst = 1'b1;
    endtask

    initial begin
        int rb;
        wrst = 1'b0; winc = 1'b0; wOvfClr = 1'b0; rptr_s = '0;
        model_reset();
        #12;
        check_all("por");
        @(negedge wclk);
        wrst = 1'b1;

        // Fill from empty with the reader idle
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, "fill");
        chk("fill_full_k",  32'(wFull), 32'd1);
        chk("fill_wptr_k",  32'(wptr),  32'b11000);
        chk("fill_waddr_k", 32'(waddr), 32'd0);
        chk("fill_level_k", 32'(wLevel), 32'd16);

        // Writes while full are dropped and flagged
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, "ovf");
        chk("ovf_wptr_k", 32'(wptr), 32'b11000);
        chk("ovf_flag_k", 32'(wOverflow), 32'd1);
`ifdef WPTR_DROP_CNT_EN
        chk("ovf_dcnt_k", 32'(wDropCnt), 32'd3);
`endif
        cyc(0, 0, 1, "ovfclr");
        chk("ovfclr_k", 32'(wOverflow), 32'd0);
        // Drop and clear together: the drop wins
        cyc(1, 0, 1, "ovfset");
        chk("ovfset_k", 32'(wOverflow), 32'd1);

        // Drain one entry, then refill it
        cyc(0, 1, 0, "drain");
        chk("drain_full_k",  32'(wFull), 32'd0);
        chk("drain_level_k", 32'(wLevel), 32'd15);
        cyc(1, 1, 0, "refill");
        chk("refill_full_k", 32'(wFull), 32'd1);

        // Almost-full threshold from empty
        apply_reset();
        for (int i = 0; i < TH - 1; i++) cyc(1, 0, 0, "afull");
        chk("afull13_k", 32'(wAlmostFull), 32'd0);
        cyc(1, 0, 0, "afull");
        chk("afull14_k", 32'(wAlmostFull), 32'd1);
        chk("afull14_level_k", 32'(wLevel), 32'd14);

        // Wrap: reader trails the writer by two cycles
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            chk("wrap_waddr_k", 32'(waddr), 32'(i % DEPTH));
            cyc(1, (i >= 2) ? (i - 2) % PMOD : 0, 0, "wrap");
        end

        // Reset asserted between edges in mid-operation
        apply_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, "pre");
        #2;
        wrst = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        chk("midrst_waddr_k", 32'(waddr), 32'd0);
        @(negedge wclk);
        wrst = 1'b1;
        chk("post_waddr_k", 32'(waddr), 32'd0);
        cyc(1, 0, 0, "post");
        chk("post_waddr1_k", 32'(waddr), 32'd1);

        // Random traffic: reader slow in the first half, fast in the second
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            int rdp;
            rdp = (i < 1500) ? 4 : 2;
            rb = m_rb;
            if (($urandom % rdp) == 0 && m_rb != m_wb) rb = (m_rb + 1) % PMOD;
            cyc(bit'(($urandom % 3) != 0), rb, bit'(($urandom % 16) == 0), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
